// File: rtl/exp_norm_adjust.sv
// exp_norm_adjust: post-addition normaliser for the FP add/sub exponent path.
// Re-normalises the raw mantissa sum one bit per cycle and corrects max_exp to match.
// Flags zero, overflow (exp saturates to all-ones) and underflow (subnormal result).
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   max_exp, sum_in     larger exponent and raw mantissa sum (MSB = carry-out)
//   sign_in/sign_out    result sign, passed through
//   out_valid/out_ready result handshake
//   exp_out, man_out    adjusted exponent and normalised mantissa (hidden bit at MSB)
//   out_sticky          LSB dropped by the carry right-shift
//   zero, overflow, underflow  mutually exclusive result flags
module exp_norm_adjust #(
    parameter int ex_width  = 8,
    parameter int man_width = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ex_width-1:0]  max_exp,
    input  logic [man_width:0]   sum_in,
    input  logic                 sign_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ex_width-1:0]  exp_out,
    output logic [man_width-1:0] man_out,
    output logic                 sign_out,
    output logic                 out_sticky,
    output logic                 zero,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [ex_width-1:0] EXP_ONE      = ex_width'(1);
    localparam logic [ex_width-1:0] EXP_ALL_ONES = '1;

    typedef enum logic [1:0] {S_IDLE, S_NORM, S_DONE} state_t;

    state_t                r_state;
    logic [man_width:0]    r_sum;
    logic [ex_width-1:0]   r_exp;

    logic                  w_carry;
    logic [ex_width-1:0]   w_lfa_b;
    logic                  w_lfa_cin;
    logic [ex_width-1:0]   w_exp_adj;
    logic                  w_lfa_cout_unused;

    // One adder serves both directions: +1 on carry, -1 (add all-ones) when shifting left.
    assign w_carry   = r_sum[man_width];
    assign w_lfa_b   = w_carry ? '0 : '1;
    assign w_lfa_cin = w_carry;

    LFA #(.width(ex_width)) u_exp_lfa (
        .i_a    (r_exp),
        .i_b    (w_lfa_b),
        .i_cin  (w_lfa_cin),
        .o_sum  (w_exp_adj),
        .o_cout (w_lfa_cout_unused)
    );

    // Control FSM and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sum      <= '0;
            r_exp      <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            exp_out    <= '0;
            man_out    <= '0;
            sign_out   <= 1'b0;
            out_sticky <= 1'b0;
            zero       <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        r_sum      <= sum_in;
                        // Subnormal operands behave as if their exponent were 1.
                        r_exp      <= (max_exp == '0) ? EXP_ONE : max_exp;
                        sign_out   <= sign_in;
                        out_sticky <= 1'b0;
                        zero       <= 1'b0;
                        overflow   <= 1'b0;
                        underflow  <= 1'b0;
                        in_ready   <= 1'b0;
                        r_state    <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (r_sum == '0) begin
                        exp_out   <= '0;
                        man_out   <= '0;
                        zero      <= 1'b1;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (w_carry) begin
                        exp_out    <= w_exp_adj;
                        man_out    <= r_sum[man_width:1];
                        out_sticky <= r_sum[0];
                        if (w_exp_adj == EXP_ALL_ONES) begin
                            overflow <= 1'b1;
                            man_out  <= '0;
                        end
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (r_sum[man_width-1]) begin
                        exp_out   <= r_exp;
                        man_out   <= r_sum[man_width-1:0];
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (r_exp == EXP_ONE) begin
                        // Exponent floor reached: leave the mantissa denormalised.
                        exp_out   <= '0;
                        man_out   <= r_sum[man_width-1:0];
                        underflow <= 1'b1;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_sum <= {r_sum[man_width-1:0], 1'b0};
                        r_exp <= w_exp_adj;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// LFA: width-bit adder with carry-in and carry-out, used for exponent +/-1.
module LFA #(
    parameter int width = 8
) (
    input  logic [width-1:0] i_a,
    input  logic [width-1:0] i_b,
    input  logic             i_cin,
    output logic [width-1:0] o_sum,
    output logic             o_cout
);

    logic [width:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{width{1'b0}}, i_cin};
    assign o_sum  = w_full[width-1:0];
    assign o_cout = w_full[width];

endmodule

// File: tb/tb_exp_norm_adjust.sv
module tb_exp_norm_adjust;

    typedef struct {
        logic [7:0]  me;
        logic [24:0] s;
        logic        sg;
        logic [7:0]  e;
        logic [23:0] m;
        logic        st;
        logic        z;
        logic        ov;
        logic        uf;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  max_exp;
    logic [24:0] sum_in;
    logic        sign_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exp_out;
    logic [23:0] man_out;
    logic        sign_out;
    logic        out_sticky;
    logic        zero;
    logic        overflow;
    logic        underflow;

    int n_checks = 0;
    int n_fail   = 0;

    exp_norm_adjust #(.ex_width(8), .man_width(24)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .max_exp    (max_exp),
        .sum_in     (sum_in),
        .sign_in    (sign_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .exp_out    (exp_out),
        .man_out    (man_out),
        .sign_out   (sign_out),
        .out_sticky (out_sticky),
        .zero       (zero),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: find the leading one and decide the shift count arithmetically.
    function automatic vec_t model(input logic [7:0] me, input logic [24:0] s, input logic sg);
        vec_t v;
        int   e;
        int   p;
        int   n;
        v    = '{me: me, s: s, sg: sg, e: 8'h0, m: 24'h0, st: 1'b0, z: 1'b0,
                 ov: 1'b0, uf: 1'b0, lat: 2};
        e    = (me == 8'h0) ? 1 : int'(me);
        if (s == 25'h0) begin
            v.z = 1'b1;
        end else if (s[24]) begin
            v.m  = 24'(s >> 1);
            v.st = s[0];
            e    = (e + 1) % 256;
            v.e  = 8'(e);
            if (e == 255) begin
                v.ov = 1'b1;
                v.m  = 24'h0;
            end
        end else begin
            p = 0;
            for (int i = 0; i < 24; i++) if (s[i]) p = i;
            n = 23 - p;
            if (n <= e - 1) begin
                v.m   = 24'(s << n);
                v.e   = 8'(e - n);
                v.lat = 2 + n;
            end else begin
                v.m   = 24'(s << (e - 1));
                v.e   = 8'h0;
                v.uf  = 1'b1;
                v.lat = 2 + e - 1;
            end
        end
        return v;
    endfunction

    task automatic check_outs(input string tag, input vec_t v);
        chk({tag, "_valid"},  32'(out_valid),  32'd1);
        chk({tag, "_exp"},    32'(exp_out),    32'(v.e));
        chk({tag, "_man"},    32'(man_out),    32'(v.m));
        chk({tag, "_sign"},   32'(sign_out),   32'(v.sg));
        chk({tag, "_sticky"}, 32'(out_sticky), 32'(v.st));
        chk({tag, "_zero"},   32'(zero),       32'(v.z));
        chk({tag, "_ovf"},    32'(overflow),   32'(v.ov));
        chk({tag, "_unf"},    32'(underflow),  32'(v.uf));
    endtask

    // Wait for in_ready, present one op, return once the accept edge has passed (cycle 1).
    task automatic accept_op(input string tag, input vec_t v);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        chk({tag, "_in_ready_wait"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        max_exp  = v.me;
        sum_in   = v.s;
        sign_in  = v.sg;
        step();
        in_valid = 1'b0;
        sum_in   = 25'($urandom);
        max_exp  = 8'($urandom);
    endtask

    task automatic run_op(input string tag, input vec_t v, input int stall);
        int cyc;
        accept_op(tag, v);
        cyc = 1;
        while (!out_valid && cyc < 60) begin
            step();
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(v.lat));
        check_outs(tag, v);
        chk({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;   // must be ignored while DONE
            sum_in    = 25'($urandom);
            step();
            check_outs({tag, "_hold"}, v);
            chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_post_valid"},    32'(out_valid), 32'd0);
        chk({tag, "_post_in_ready"}, 32'(in_ready),  32'd1);
    endtask

    vec_t vecs[8];
    vec_t rv;

    initial begin
        // Hand-computed directed vectors.
        vecs[0] = '{me: 8'h80, s: 25'h0800000, sg: 1'b0, e: 8'h80, m: 24'h800000, st: 1'b0, z: 1'b0, ov: 1'b0, uf: 1'b0, lat: 2};
        vecs[1] = '{me: 8'h7F, s: 25'h1000001, sg: 1'b1, e: 8'h80, m: 24'h800000, st: 1'b1, z: 1'b0, ov: 1'b0, uf: 1'b0, lat: 2};
        vecs[2] = '{me: 8'h80, s: 25'h0000100, sg: 1'b0, e: 8'h71, m: 24'h800000, st: 1'b0, z: 1'b0, ov: 1'b0, uf: 1'b0, lat: 17};
        vecs[3] = '{me: 8'h03, s: 25'h0000001, sg: 1'b1, e: 8'h00, m: 24'h000004, st: 1'b0, z: 1'b0, ov: 1'b0, uf: 1'b1, lat: 4};
        vecs[4] = '{me: 8'hFE, s: 25'h1000000, sg: 1'b0, e: 8'hFF, m: 24'h000000, st: 1'b0, z: 1'b0, ov: 1'b1, uf: 1'b0, lat: 2};
        vecs[5] = '{me: 8'h00, s: 25'h0400000, sg: 1'b0, e: 8'h00, m: 24'h400000, st: 1'b0, z: 1'b0, ov: 1'b0, uf: 1'b1, lat: 2};
        vecs[6] = '{me: 8'h00, s: 25'h0800000, sg: 1'b1, e: 8'h01, m: 24'h800000, st: 1'b0, z: 1'b0, ov: 1'b0, uf: 1'b0, lat: 2};
        vecs[7] = '{me: 8'h40, s: 25'h0000003, sg: 1'b0, e: 8'h2A, m: 24'hC00000, st: 1'b0, z: 1'b0, ov: 1'b0, uf: 1'b0, lat: 24};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        max_exp   = 8'h0;
        sum_in    = 25'h0;
        sign_in   = 1'b0;

        repeat (3) step();
        chk("rst_in_ready",  32'(in_ready),   32'd0);
        chk("rst_out_valid", 32'(out_valid),  32'd0);
        chk("rst_exp",       32'(exp_out),    32'd0);
        chk("rst_man",       32'(man_out),    32'd0);
        chk("rst_flags",     32'({sign_out, out_sticky, zero, overflow, underflow}), 32'd0);
        rst = 1'b0;
        step();
        chk("rst_release_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 8; i++) run_op($sformatf("vec%0d", i), vecs[i], i % 3);

        // Zero result with a 5-cycle downstream stall.
        run_op("zero_stall", '{me: 8'h55, s: 25'h0, sg: 1'b1, e: 8'h00, m: 24'h0, st: 1'b0,
                               z: 1'b1, ov: 1'b0, uf: 1'b0, lat: 2}, 5);

        // Reset in the middle of a long normalisation, then a fresh op.
        accept_op("rst_mid", vecs[2]);
        repeat (7) step();
        chk("rst_mid_busy", 32'(in_ready | out_valid), 32'd0);
        rst = 1'b1;
        step();
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_flags",     32'({out_sticky, zero, overflow, underflow}), 32'd0);
        chk("rst_mid_in_ready",  32'(in_ready), 32'd0);
        rst = 1'b0;
        step();
        chk("rst_mid_release", 32'(in_ready), 32'd1);
        run_op("after_rst", vecs[0], 0);

        // Random operands against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [24:0] s;
            s = 25'($urandom) >> $urandom_range(0, 26);
            rv = model(8'($urandom), s, 1'($urandom));
            run_op($sformatf("rnd%0d", i), rv, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog timeout");
    end

endmodule
